// File: rtl/time_entry.sv
// Front panel for the countdown timer: debounced buttons, min/sec entry, run/finish control.
// Optional macro TIME_ENTRY_CARRY_EN: seconds inc/dec carries into / borrows from minutes.
module time_entry #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned RPT_DELAY  = 25000000,
    parameter int unsigned RPT_PERIOD = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_sel,
    input  logic       btn_start,
    input  logic       done,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       sel_field,
    output logic       timer_rst_n,
    output logic       running
);

    localparam int unsigned NB      = 4;
    localparam int unsigned NR      = 2;
    localparam int unsigned DW      = $clog2(DEB_CYCLES + 1);
    localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);
    localparam logic [5:0]  MAX_VAL = 6'd59;

    typedef enum logic [1:0] {EDIT, RUN, FIN} state_t;

    // Button order: 0 = inc, 1 = dec, 2 = sel, 3 = start
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1, sync2;
    logic [NB-1:0] level, level_q;
    logic [DW-1:0] deb_cnt [NB];
    logic [NB-1:0] press_c;
    logic [RW-1:0] rpt_cnt [NR];
    logic [NR-1:0] rpt_first;
    logic [NR-1:0] rpt_c;

    state_t     state, state_n;
    logic [5:0] min_n, sec_n;
    logic       sel_n;
    logic       inc_evt, dec_evt, sel_evt, start_evt, any_press;

    assign raw = {btn_start, btn_sel, btn_dec, btn_inc};

    function automatic logic [5:0] up6(input logic [5:0] v);
        return (v >= MAX_VAL) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dn6(input logic [5:0] v);
        return (v == 6'd0 || v > MAX_VAL) ? MAX_VAL : v - 6'd1;
    endfunction

    // Synchronise, then debounce: level follows input after DEB_CYCLES consecutive disagreements
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] != level[i]) begin
                    if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                        level[i]   <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign press_c = level & ~level_q;

    always_comb begin
        rpt_c = '0;
        for (int j = 0; j < NR; j++) begin
            rpt_c[j] = level[j] && !press_c[j] &&
                       (rpt_cnt[j] == (rpt_first[j] ? RW'(RPT_DELAY) : RW'(RPT_PERIOD)));
        end
    end

    // Auto-repeat timers for inc/dec; counter holds cycles since the last event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_first <= '0;
            for (int j = 0; j < NR; j++) rpt_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < NR; j++) begin
                if (press_c[j]) begin
                    rpt_cnt[j]   <= RW'(1);
                    rpt_first[j] <= 1'b1;
                end else if (level[j]) begin
                    if (rpt_c[j]) begin
                        rpt_cnt[j]   <= RW'(1);
                        rpt_first[j] <= 1'b0;
                    end else begin
                        rpt_cnt[j] <= rpt_cnt[j] + RW'(1);
                    end
                end else begin
                    rpt_cnt[j]   <= '0;
                    rpt_first[j] <= 1'b0;
                end
            end
        end
    end

    assign inc_evt   = press_c[0] | rpt_c[0];
    assign dec_evt   = press_c[1] | rpt_c[1];
    assign sel_evt   = press_c[2];
    assign start_evt = press_c[3];
    assign any_press = |press_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EDIT;
        else     state <= state_n;
    end

    // Next state and next min/sec/field values
    always_comb begin
        state_n = state;
        min_n   = min;
        sec_n   = sec;
        sel_n   = sel_field;
        case (state)
            EDIT: begin
                if (start_evt) begin
                    if (min != 6'd0 || sec != 6'd0) state_n = RUN;
                end else begin
                    if (inc_evt ^ dec_evt) begin
                        if (sel_field) begin
                            min_n = inc_evt ? up6(min) : dn6(min);
                        end else begin
                            sec_n = inc_evt ? up6(sec) : dn6(sec);
`ifdef TIME_ENTRY_CARRY_EN
                            if (inc_evt && sec >= MAX_VAL) min_n = up6(min);
                            if (dec_evt && sec == 6'd0)    min_n = dn6(min);
`else
`endif
                        end
                    end
                    if (sel_evt) sel_n = ~sel_field;
                end
            end
            RUN: begin
                if (done)           state_n = FIN;
                else if (start_evt) state_n = EDIT;
            end
            FIN: begin
                if (any_press) state_n = EDIT;
            end
            default: state_n = EDIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min         <= '0;
            sec         <= '0;
            sel_field   <= 1'b0;
            timer_rst_n <= 1'b0;
            running     <= 1'b0;
        end else begin
            min         <= min_n;
            sec         <= sec_n;
            sel_field   <= sel_n;
            timer_rst_n <= (state_n != EDIT);
            running     <= (state_n == RUN);
        end
    end

endmodule
